// File: rtl/emu_time_ctrl_if.sv
// Control and time-step bundle between the control generator / models
// (master) and the emulation time manager (slave).
interface emu_time_ctrl_if #(
    parameter int TIME_WIDTH = 64,
    parameter int DT_WIDTH   = 32,
    parameter int DEC_WIDTH  = 24
);
    logic [1:0]            emu_ctrl_mode;
    logic [TIME_WIDTH-1:0] emu_ctrl_data;
    logic [DEC_WIDTH-1:0]  emu_dec_thr;
    logic [DT_WIDTH-1:0]   dt_req;
    logic [TIME_WIDTH-1:0] emu_time;
    logic [DT_WIDTH-1:0]   emu_dt;
    logic                  emu_stall;
    logic                  emu_dec_cmp;

    modport master (
        output emu_ctrl_mode, emu_ctrl_data, emu_dec_thr, dt_req,
        input  emu_time, emu_dt, emu_stall, emu_dec_cmp
    );

    modport slave (
        input  emu_ctrl_mode, emu_ctrl_data, emu_dec_thr, dt_req,
        output emu_time, emu_dt, emu_stall, emu_dec_cmp
    );
endinterface

// File: rtl/emu_time_ctrl.sv
// Emulation time manager: advances global time, grants per-cycle steps
// (run / hold / stall-at / sleep) and produces the probe decimation strobe.
module emu_time_ctrl #(
    parameter int TIME_WIDTH = 64,
    parameter int DT_WIDTH   = 32,
    parameter int DEC_WIDTH  = 24
) (
    input  logic              emu_clk,
    input  logic              emu_rst,
    emu_time_ctrl_if.slave    bus
);
    localparam logic [TIME_WIDTH-1:0] TMAX      = {TIME_WIDTH{1'b1}};
    localparam logic [TIME_WIDTH-1:0] TIME_ZERO = {TIME_WIDTH{1'b0}};
    localparam logic [DT_WIDTH-1:0]   DT_ZERO   = {DT_WIDTH{1'b0}};
    localparam logic [DEC_WIDTH-1:0]  DEC_ZERO  = {DEC_WIDTH{1'b0}};
    localparam logic [DEC_WIDTH-1:0]  DEC_ONE   = {{(DEC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_HOLD  = 2'b01;
    localparam logic [1:0] MODE_STALL = 2'b10;
    localparam logic [1:0] MODE_SLEEP = 2'b11;

    typedef enum logic [2:0] {
        ST_RUN  = 3'd0,
        ST_HOLD = 3'd1,
        ST_ARM  = 3'd2,
        ST_SEEK = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    logic [1:0]            mode_d, mode_q, mode_qq;
    logic [TIME_WIDTH-1:0] data_d, data_q, data_qq;
    logic [TIME_WIDTH-1:0] time_d, time_q;
    logic [TIME_WIDTH-1:0] target_d, target_q;
    logic [DEC_WIDTH-1:0]  dec_cnt_d, dec_cnt_q;

    logic                  arm_s;
    state_e                state_s;
    logic [TIME_WIDTH-1:0] eff_target_s;
    logic [TIME_WIDTH-1:0] dt_req_ext_s;
    logic [DT_WIDTH-1:0]   dt_s;
    logic                  dec_cmp_s;

    function automatic logic [TIME_WIDTH-1:0] sat_add(
        input logic [TIME_WIDTH-1:0] a,
        input logic [TIME_WIDTH-1:0] b
    );
        logic [TIME_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[TIME_WIDTH]) begin
            return TMAX;
        end else begin
            return sum[TIME_WIDTH-1:0];
        end
    endfunction

    // Compare at full time width; only the winner (never above req) is narrowed.
    function automatic logic [DT_WIDTH-1:0] min_step(
        input logic [TIME_WIDTH-1:0] req,
        input logic [TIME_WIDTH-1:0] room
    );
        logic [TIME_WIDTH-1:0] sel;
        sel = (req < room) ? req : room;
        return DT_WIDTH'(sel);
    endfunction

    assign dt_req_ext_s = {{(TIME_WIDTH-DT_WIDTH){1'b0}}, bus.dt_req};
    assign arm_s = (mode_q == MODE_SLEEP) && ((mode_q != mode_qq) || (data_q != data_qq));

    // Decode the operating state from the registered mode, arm event and target.
    always_comb begin
        state_s      = ST_HOLD;
        eff_target_s = data_q;
        case (mode_q)
            MODE_RUN:   state_s = ST_RUN;
            MODE_HOLD:  state_s = ST_HOLD;
            MODE_STALL: begin
                eff_target_s = data_q;
                state_s      = (time_q < data_q) ? ST_SEEK : ST_DONE;
            end
            MODE_SLEEP: begin
                eff_target_s = target_q;
                if (arm_s) begin
                    state_s = ST_ARM;
                end else if (time_q < target_q) begin
                    state_s = ST_SEEK;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default:    state_s = ST_HOLD;
        endcase
    end

    // Grant this cycle's step; seek steps are clipped to land exactly on the target.
    always_comb begin
        dt_s = DT_ZERO;
        case (state_s)
            ST_RUN:  dt_s = min_step(dt_req_ext_s, TMAX - time_q);
            ST_SEEK: dt_s = min_step(dt_req_ext_s, eff_target_s - time_q);
            default: dt_s = DT_ZERO;
        endcase
    end

    // Next-state for time, sleep target, decimation counter and input pipeline.
    always_comb begin
        mode_d    = bus.emu_ctrl_mode;
        data_d    = bus.emu_ctrl_data;
        time_d    = time_q + {{(TIME_WIDTH-DT_WIDTH){1'b0}}, dt_s};
        target_d  = target_q;
        dec_cnt_d = dec_cnt_q;
        dec_cmp_s = 1'b0;
        if (state_s == ST_ARM) begin
            target_d = sat_add(time_q, data_q);
        end else begin
            target_d = target_q;
        end
        if (dt_s != DT_ZERO) begin
            if (dec_cnt_q >= bus.emu_dec_thr) begin
                dec_cmp_s = 1'b1;
                dec_cnt_d = DEC_ZERO;
            end else begin
                dec_cnt_d = dec_cnt_q + DEC_ONE;
            end
        end else begin
            dec_cnt_d = dec_cnt_q;
        end
    end

    // State registers; reset lands in HOLD with time, target and counter cleared.
    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            mode_q    <= MODE_HOLD;
            mode_qq   <= MODE_HOLD;
            data_q    <= TIME_ZERO;
            data_qq   <= TIME_ZERO;
            time_q    <= TIME_ZERO;
            target_q  <= TIME_ZERO;
            dec_cnt_q <= DEC_ZERO;
        end else begin
            mode_q    <= mode_d;
            mode_qq   <= mode_q;
            data_q    <= data_d;
            data_qq   <= data_q;
            time_q    <= time_d;
            target_q  <= target_d;
            dec_cnt_q <= dec_cnt_d;
        end
    end

    assign bus.emu_time    = time_q;
    assign bus.emu_dt      = dt_s;
    assign bus.emu_stall   = (dt_s == DT_ZERO);
    assign bus.emu_dec_cmp = dec_cmp_s;
endmodule
